// File: rtl/pc_sequencer.sv
// Program counter with a circular return stack for the PIC-style core.
// Handles sequential fetch, skip, jumps, calls, returns and interrupt vectoring.
module pc_sequencer #(
    parameter int PC_W      = 13,
    parameter int TGT_W     = 11,
    parameter int DEPTH     = 8,
    parameter int RESET_VEC = 0,
    parameter int INT_VEC   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic [2:0]                   op,
    input  logic [TGT_W-1:0]             target,
    input  logic [PC_W-TGT_W-1:0]        page_hi,
    input  logic                         clr_err,
    output logic [PC_W-1:0]              pc,
    output logic [PC_W-1:0]              tos,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         full,
    output logic                         empty,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int SP_W  = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic [2:0] {
        OP_NEXT = 3'd0,
        OP_SKIP = 3'd1,
        OP_GOTO = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4,
        OP_INT  = 3'd5
    } op_e;

    logic [PC_W-1:0]  mem [DEPTH];
    logic [SP_W-1:0]  wp;

    logic [PC_W-1:0]  pc_n;
    logic [SP_W-1:0]  wp_n;
    logic [CNT_W-1:0] depth_n;
    logic             overflow_n;
    logic             underflow_n;
    logic             push;
    logic [PC_W-1:0]  push_val;
    logic             ovf_set;
    logic             unf_set;
    op_e              op_d;

    assign tos   = mem[wp - SP_W'(1)];
    assign full  = (depth == CNT_W'(DEPTH));
    assign empty = (depth == '0);

    always_comb begin
        op_d        = op_e'(op);
        pc_n        = pc + PC_W'(1);
        wp_n        = wp;
        depth_n     = depth;
        push        = 1'b0;
        push_val    = '0;
        ovf_set     = 1'b0;
        unf_set     = 1'b0;

        case (op_d)
            OP_SKIP: pc_n = pc + PC_W'(2);
            OP_GOTO: pc_n = {page_hi, target};
            OP_CALL: begin
                push     = 1'b1;
                push_val = pc + PC_W'(1);
                pc_n     = {page_hi, target};
            end
            OP_INT: begin
                push     = 1'b1;
                push_val = pc;
                pc_n     = PC_W'(INT_VEC);
            end
            OP_RET: begin
                if (!empty) begin
                    pc_n    = tos;
                    wp_n    = wp - SP_W'(1);
                    depth_n = depth - CNT_W'(1);
                end else begin
                    unf_set = 1'b1;
                end
            end
            default: pc_n = pc + PC_W'(1);
        endcase

        // A push while full overwrites the oldest entry: wp advances, depth saturates.
        if (push) begin
            wp_n = wp + SP_W'(1);
            if (full) ovf_set = 1'b1;
            else      depth_n = depth + CNT_W'(1);
        end

        overflow_n  = ovf_set | (overflow  & ~clr_err);
        underflow_n = unf_set | (underflow & ~clr_err);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= PC_W'(RESET_VEC);
            wp        <= '0;
            depth     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (!stall) begin
            pc        <= pc_n;
            wp        <= wp_n;
            depth     <= depth_n;
            overflow  <= overflow_n;
            underflow <= underflow_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !stall && push) mem[wp] <= push_val;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer with hand-computed expectations.
// Each task drives one scenario and checks outputs 1 time unit after the edge.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [2:0]  op;
    logic [10:0] target;
    logic [1:0]  page_hi;
    logic        clr_err;
    logic [12:0] pc;
    logic [12:0] tos;
    logic [3:0]  depth;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        underflow;

    int checks   = 0;
    int failures = 0;

    localparam logic [2:0] NEXT = 3'd0, SKIP = 3'd1, GOTO = 3'd2,
                           CALL = 3'd3, RET  = 3'd4, INT  = 3'd5;

    pc_sequencer #(.PC_W(13), .TGT_W(11), .DEPTH(8), .RESET_VEC(0), .INT_VEC(4)) dut (
        .clk(clk), .reset(reset), .stall(stall), .op(op), .target(target),
        .page_hi(page_hi), .clr_err(clr_err), .pc(pc), .tos(tos), .depth(depth),
        .full(full), .empty(empty), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic cycle(input logic [2:0] o, input logic [12:0] addr);
        op      = o;
        page_hi = addr[12:11];
        target  = addr[10:0];
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; stall = 1'b0; clr_err = 1'b0;
        cycle(NEXT, 13'h0);
        reset = 1'b0;
        checks++; if (pc !== 13'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0000", pc); end
        checks++; if (depth !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
            failures++; $display("FAIL reset_depth depth=%0d empty=%b full=%b exp 0/1/0", depth, empty, full); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
            failures++; $display("FAIL reset_flags ovf=%b unf=%b exp 0/0", overflow, underflow); end
    endtask

    task automatic test_next_skip;
        cycle(NEXT, 13'h0);
        checks++; if (pc !== 13'h1) begin failures++; $display("FAIL next1 got=%h exp=0001", pc); end
        cycle(NEXT, 13'h0);
        checks++; if (pc !== 13'h2) begin failures++; $display("FAIL next2 got=%h exp=0002", pc); end
        cycle(3'd7, 13'h0);
        checks++; if (pc !== 13'h3) begin failures++; $display("FAIL op7_next got=%h exp=0003", pc); end
        cycle(SKIP, 13'h0);
        checks++; if (pc !== 13'h5) begin failures++; $display("FAIL skip got=%h exp=0005", pc); end
        checks++; if (depth !== 4'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            failures++; $display("FAIL seq_state depth=%0d ovf=%b unf=%b exp 0/0/0", depth, overflow, underflow); end
        cycle(GOTO, 13'h1FFF);
        cycle(SKIP, 13'h0);
        checks++; if (pc !== 13'h0001) begin failures++; $display("FAIL pc_wrap got=%h exp=0001", pc); end
    endtask

    task automatic test_call_ret;
        cycle(GOTO, 13'h010);
        checks++; if (pc !== 13'h010) begin failures++; $display("FAIL goto got=%h exp=0010", pc); end
        cycle(CALL, 13'h0923);
        checks++; if (pc !== 13'h0923) begin failures++; $display("FAIL call_pc got=%h exp=0923", pc); end
        checks++; if (tos !== 13'h011 || depth !== 4'd1) begin
            failures++; $display("FAIL call_stack tos=%h depth=%0d exp 0011/1", tos, depth); end
        cycle(RET, 13'h0);
        checks++; if (pc !== 13'h011 || depth !== 4'd0) begin
            failures++; $display("FAIL ret pc=%h depth=%0d exp 0011/0", pc, depth); end
    endtask

    task automatic test_overflow_underflow;
        cycle(GOTO, 13'h020);
        for (int i = 0; i < 9; i++) cycle(CALL, 13'h100);
        checks++; if (depth !== 4'd8 || full !== 1'b1 || overflow !== 1'b1) begin
            failures++; $display("FAIL ovf_state depth=%0d full=%b ovf=%b exp 8/1/1", depth, full, overflow); end
        checks++; if (tos !== 13'h101) begin failures++; $display("FAIL ovf_tos got=%h exp=0101", tos); end
        for (int i = 0; i < 8; i++) begin
            cycle(RET, 13'h0);
            checks++; if (pc !== 13'h101 || depth !== 4'(7 - i)) begin
                failures++; $display("FAIL ovf_ret%0d pc=%h depth=%0d exp 0101/%0d", i, pc, depth, 7 - i); end
        end
        checks++; if (overflow !== 1'b1 || underflow !== 1'b0 || empty !== 1'b1) begin
            failures++; $display("FAIL flags_sticky ovf=%b unf=%b empty=%b exp 1/0/1", overflow, underflow, empty); end
        cycle(RET, 13'h0);
        checks++; if (pc !== 13'h102 || underflow !== 1'b1 || depth !== 4'd0) begin
            failures++; $display("FAIL underflow pc=%h unf=%b depth=%0d exp 0102/1/0", pc, underflow, depth); end
        clr_err = 1'b1;
        cycle(NEXT, 13'h0);
        clr_err = 1'b0;
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
            failures++; $display("FAIL clr_err ovf=%b unf=%b exp 0/0", overflow, underflow); end
    endtask

    task automatic test_interrupt;
        cycle(GOTO, 13'h033);
        cycle(INT, 13'h1555);
        checks++; if (pc !== 13'h004 || tos !== 13'h033 || depth !== 4'd1) begin
            failures++; $display("FAIL int pc=%h tos=%h depth=%0d exp 0004/0033/1", pc, tos, depth); end
        cycle(RET, 13'h0);
        checks++; if (pc !== 13'h033 || depth !== 4'd0) begin
            failures++; $display("FAIL int_ret pc=%h depth=%0d exp 0033/0", pc, depth); end
    endtask

    task automatic test_stall;
        cycle(GOTO, 13'h040);
        cycle(CALL, 13'h050);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clr_err = 1'b1;
            cycle(CALL, 13'h200);
            checks++; if (pc !== 13'h050 || depth !== 4'd1 || tos !== 13'h041) begin
                failures++; $display("FAIL stall%0d pc=%h depth=%0d tos=%h exp 0050/1/0041", i, pc, depth, tos); end
        end
        stall = 1'b0; clr_err = 1'b0;
        cycle(CALL, 13'h200);
        cycle(NEXT, 13'h0);
        checks++; if (pc !== 13'h201 || depth !== 4'd2 || tos !== 13'h051) begin
            failures++; $display("FAIL stall_release pc=%h depth=%0d tos=%h exp 0201/2/0051", pc, depth, tos); end
        cycle(RET, 13'h0);
        cycle(RET, 13'h0);
        checks++; if (pc !== 13'h041 || depth !== 4'd0) begin
            failures++; $display("FAIL stall_unwind pc=%h depth=%0d exp 0041/0", pc, depth); end
    endtask

    task automatic test_reset_mid_and_clr_race;
        cycle(RET, 13'h0);
        for (int i = 0; i < 5; i++) cycle(CALL, 13'h060);
        checks++; if (depth !== 4'd5 || underflow !== 1'b1) begin
            failures++; $display("FAIL pre_reset depth=%0d unf=%b exp 5/1", depth, underflow); end
        reset = 1'b1;
        cycle(CALL, 13'h070);
        reset = 1'b0;
        checks++; if (pc !== 13'h0 || depth !== 4'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            failures++; $display("FAIL reset_mid pc=%h depth=%0d ovf=%b unf=%b exp 0000/0/0/0", pc, depth, overflow, underflow); end
        clr_err = 1'b1;
        cycle(RET, 13'h0);
        clr_err = 1'b0;
        checks++; if (underflow !== 1'b1 || pc !== 13'h0001) begin
            failures++; $display("FAIL clr_vs_set unf=%b pc=%h exp 1/0001", underflow, pc); end
    endtask

    initial begin
        op = NEXT; target = '0; page_hi = '0;
        test_reset;
        test_next_skip;
        test_call_ret;
        test_overflow_underflow;
        test_interrupt;
        test_stall;
        test_reset_mid_and_clr_race;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
